poly_vector_accelerator: RTL and testbench

Parametrised successor to the single-coefficient vector squarer: a host loads a vector length, three programmable coefficients and up to DEPTH unsigned samples over a 32-bit word stream. On trigger, the block computes y[i] = A·x[i]² + B·x[i] + C through a 3-stage pipeline at one element per cycle. Results are then streamed back on read requests. The block sits behind the same host-facing word interface as the existing accelerators.

---
 rtl/poly_accel_pkg.sv | 19 +
 rtl/poly_accel_datapath.sv | 80 ++++++++
 rtl/poly_vector_accelerator.sv | 214 +++++++++++++++++++++
 tb/tb_poly_vector_accelerator.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_accel_pkg.sv
// Shared types and constants for the polynomial vector accelerator.
// The optional POLY_ACCEL_SATURATE_EN macro is consumed by poly_accel_datapath.
package poly_accel_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 10;
    localparam int COEF_COUNT     = 3;
    localparam int PIPE_LAT       = 3;

    typedef enum logic [2:0] {
        IDLE,
        RX_SIZE,
        RX_COEF,
        RX_DATA,
        COMPUTE,
        TX
    } state_t;

endpackage

// File: rtl/poly_accel_datapath.sv
// Multiply-add pipeline computing A*x^2 + B*x + C with valid/address sideband.
// Define POLY_ACCEL_SATURATE_EN to clamp results that overflow DATA_W to all-ones.
module poly_accel_datapath
    import poly_accel_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] x_data,
    input  logic [DATA_W-1:0] coef_a,
    input  logic [DATA_W-1:0] coef_b,
    input  logic [DATA_W-1:0] coef_c,
    output logic              res_valid,
    output logic [ADDR_W-1:0] res_addr,
    output logic [DATA_W-1:0] res_data
);

    // Wrap-only builds keep just the low DATA_W bits of every product, which are exact mod 2^DATA_W.
`ifdef POLY_ACCEL_SATURATE_EN
    localparam int SQ_W  = 2 * DATA_W;
    localparam int RES_W = 3 * DATA_W + 1;
`else
    localparam int SQ_W  = DATA_W;
    localparam int RES_W = DATA_W;
`endif

    logic [PIPE_LAT-1:0] valid_pipe;
    logic [ADDR_W-1:0]   addr_pipe [PIPE_LAT];
    logic [SQ_W-1:0]     x_sq;
    logic [SQ_W-1:0]     b_x;
    logic [RES_W-1:0]    sum_full;

    // Stage 1 of the sideband lines up with the registered RAM output in x_data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_pipe <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                addr_pipe[i] <= '0;
            end
        end else begin
            valid_pipe   <= {valid_pipe[PIPE_LAT-2:0], issue_valid};
            addr_pipe[0] <= issue_addr;
            for (int i = 1; i < PIPE_LAT; i++) begin
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_sq <= '0;
            b_x  <= '0;
        end else begin
            x_sq <= SQ_W'(x_data) * SQ_W'(x_data);
            b_x  <= SQ_W'(coef_b) * SQ_W'(x_data);
        end
    end

    assign sum_full = RES_W'(coef_a) * RES_W'(x_sq) + RES_W'(b_x) + RES_W'(coef_c);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_data <= '0;
        end else begin
`ifdef POLY_ACCEL_SATURATE_EN
            res_data <= (sum_full[RES_W-1:DATA_W] != '0) ? {DATA_W{1'b1}} : sum_full[DATA_W-1:0];
`else
            res_data <= sum_full;
`endif
        end
    end

    assign res_valid = valid_pipe[PIPE_LAT-1];
    assign res_addr  = addr_pipe[PIPE_LAT-1];

endmodule

// File: rtl/poly_vector_accelerator.sv
// Host-facing polynomial vector accelerator: word-stream load, pipelined compute, streamed readback.
// Result saturation is built in when POLY_ACCEL_SATURATE_EN is defined (see poly_accel_datapath).
module poly_vector_accelerator
    import poly_accel_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              enable,
    input  logic              trigger_computation,
    input  logic              wr_enable,
    input  logic              rd_enable,
    output logic [DATA_W-1:0] out_data,
    output logic              valid_output,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int               DEPTH     = 1 << ADDR_W;
    localparam int               CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_COEF = CNT_W'(COEF_COUNT - 1);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  size;
    logic [CNT_W-1:0]  size_word;
    logic [DATA_W-1:0] coef_a;
    logic [DATA_W-1:0] coef_b;
    logic [DATA_W-1:0] coef_c;
    logic              loaded;
    logic              size_bad;
    logic              cnt_last;
    logic              last_res;

    logic [DATA_W-1:0] x_mem [DEPTH];
    logic [DATA_W-1:0] y_mem [DEPTH];
    logic [DATA_W-1:0] x_rd;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic              res_valid;
    logic [ADDR_W-1:0] res_addr;
    logic [DATA_W-1:0] res_data;

    assign size_word   = in_data[CNT_W-1:0];
    assign size_bad    = (size_word == '0) || (size_word > DEPTH_CNT);
    assign cnt_last    = (cnt + 1'b1) == size;
    assign issue_valid = (state == COMPUTE) && (cnt < size);
    assign issue_addr  = cnt[ADDR_W-1:0];
    assign last_res    = res_valid && ({1'b0, res_addr} == size - 1'b1);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    next_state = RX_SIZE;
                end else if (trigger_computation && loaded) begin
                    next_state = COMPUTE;
                end
            end
            RX_SIZE: begin
                if (wr_enable) begin
                    next_state = size_bad ? IDLE : RX_COEF;
                end
            end
            RX_COEF: begin
                if (wr_enable && (cnt == LAST_COEF)) begin
                    next_state = RX_DATA;
                end
            end
            RX_DATA: begin
                if (wr_enable && cnt_last) begin
                    next_state = IDLE;
                end
            end
            COMPUTE: begin
                if (last_res) begin
                    next_state = TX;
                end
            end
            TX: begin
                if (rd_enable && cnt_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // cnt is shared: coefficient index, sample write address, issue address and readback address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            size         <= '0;
            coef_a       <= '0;
            coef_b       <= '0;
            coef_c       <= '0;
            loaded       <= 1'b0;
            error        <= 1'b0;
            valid_output <= 1'b0;
            done         <= 1'b0;
            out_data     <= '0;
        end else begin
            valid_output <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        error  <= 1'b0;
                        loaded <= 1'b0;
                        cnt    <= '0;
                    end else if (trigger_computation && loaded) begin
                        cnt <= '0;
                    end
                end
                RX_SIZE: begin
                    if (wr_enable) begin
                        size <= size_word;
                        cnt  <= '0;
                        if (size_bad) begin
                            error <= 1'b1;
                        end
                    end
                end
                RX_COEF: begin
                    if (wr_enable) begin
                        if (cnt == '0) begin
                            coef_a <= in_data;
                        end else if (cnt == CNT_W'(1)) begin
                            coef_b <= in_data;
                        end else begin
                            coef_c <= in_data;
                        end
                        cnt <= (cnt == LAST_COEF) ? '0 : cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (wr_enable) begin
                        cnt <= cnt + 1'b1;
                        if (cnt_last) begin
                            loaded <= 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (issue_valid) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (last_res) begin
                        cnt <= '0;
                    end
                end
                TX: begin
                    if (rd_enable) begin
                        out_data     <= y_mem[cnt[ADDR_W-1:0]];
                        valid_output <= 1'b1;
                        cnt          <= cnt + 1'b1;
                        if (cnt_last) begin
                            done <= 1'b1;
                        end
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Block-RAM style buffers: no reset, so contents survive reset_n.
    always_ff @(posedge clk) begin
        if ((state == RX_DATA) && wr_enable) begin
            x_mem[cnt[ADDR_W-1:0]] <= in_data;
        end
        if (res_valid) begin
            y_mem[res_addr] <= res_data;
        end
        x_rd <= x_mem[issue_addr];
    end

    poly_accel_datapath #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_datapath (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .x_data      (x_rd),
        .coef_a      (coef_a),
        .coef_b      (coef_b),
        .coef_c      (coef_c),
        .res_valid   (res_valid),
        .res_addr    (res_addr),
        .res_data    (res_data)
    );

endmodule

// File: tb/tb_poly_vector_accelerator.sv
// Randomized self-checking bench for poly_vector_accelerator against a plain-arithmetic reference.
// The reference follows POLY_ACCEL_SATURATE_EN the same way the build does.
module tb_poly_vector_accelerator;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DATA_W-1:0] in_data;
    logic              enable;
    logic              trigger_computation;
    logic              wr_enable;
    logic              rd_enable;
    logic [DATA_W-1:0] out_data;
    logic              valid_output;
    logic              busy;
    logic              done;
    logic              error;

    poly_vector_accelerator #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .in_data             (in_data),
        .enable              (enable),
        .trigger_computation (trigger_computation),
        .wr_enable           (wr_enable),
        .rd_enable           (rd_enable),
        .out_data            (out_data),
        .valid_output        (valid_output),
        .busy                (busy),
        .done                (done),
        .error               (error)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] xq[$];
    logic [31:0] expq[$];
    logic [31:0] got[$];
    int          first_lat;
    int          last_lat;
    int          done_cnt;
    bit          done_on_last;
    bit          timed_out;

    function automatic logic [31:0] poly_ref(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] c, input logic [31:0] x);
        logic [127:0] full;
        full = 128'(a) * 128'(x) * 128'(x) + 128'(b) * 128'(x) + 128'(c);
`ifdef POLY_ACCEL_SATURATE_EN
        if (full > 128'h0_FFFF_FFFF) return 32'hFFFF_FFFF;
`endif
        return full[31:0];
    endfunction

    task automatic load_vector(input logic [31:0] size_word, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] c);
        @(negedge clk); enable = 1'b1;
        @(negedge clk); enable = 1'b0; wr_enable = 1'b1; in_data = size_word;
        @(negedge clk); in_data = a;
        @(negedge clk); in_data = b;
        @(negedge clk); in_data = c;
        foreach (xq[i]) begin
            @(negedge clk); in_data = xq[i];
        end
        @(negedge clk); wr_enable = 1'b0; in_data = $urandom;
        expq.delete();
        foreach (xq[i]) expq.push_back(poly_ref(a, b, c, xq[i]));
    endtask

    task automatic compute_and_read(input int n, input bit continuous);
        got.delete();
        first_lat = -1; last_lat = -1; done_cnt = 0; done_on_last = 1'b0; timed_out = 1'b0;
        @(negedge clk); trigger_computation = 1'b1; rd_enable = continuous;
        @(negedge clk); trigger_computation = 1'b0;
        for (int k = 1; got.size() < n; k++) begin
            if (k > 4 * n + 64) begin
                timed_out = 1'b1;
                break;
            end
            if (!continuous) rd_enable = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (valid_output) begin
                if (first_lat < 0) first_lat = k;
                last_lat = k;
                got.push_back(out_data);
            end
            if (done) begin
                done_cnt++;
                done_on_last = valid_output && (got.size() == n);
            end
        end
        rd_enable = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (valid_output) got.push_back(out_data);
        end
        rd_enable = 1'b0;
    endtask

    task automatic check_run(input string name, input int n);
        vectors++;
        if (timed_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s_timeout: got %0d results, expected %0d", name, got.size(), n);
        end
        vectors++;
        if (got.size() !== n) begin
            miscompares++;
            $display("[TB] FAIL %s_count: got %0d, expected %0d", name, got.size(), n);
        end
        foreach (expq[i]) begin
            vectors++;
            if (i >= got.size() || got[i] !== expq[i]) begin
                miscompares++;
                $display("[TB] FAIL %s_y[%0d]: got %h, expected %h", name, i,
                         (i < got.size()) ? got[i] : 32'hx, expq[i]);
            end
        end
        vectors++;
        if (done_cnt !== 1 || done_on_last !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s_done: got %0d pulses (on_last=%0d), expected 1 (on_last=1)",
                     name, done_cnt, done_on_last);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s_busy_after: got %b, expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; trigger_computation = 1'b0;
        wr_enable = 1'b0; rd_enable = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        vectors += 5;
        if (out_data !== 32'd0)   begin miscompares++; $display("[TB] FAIL reset_out_data: got %h, expected 0", out_data); end
        if (valid_output !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b, expected 0", valid_output); end
        if (busy !== 1'b0)         begin miscompares++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        if (done !== 1'b0)         begin miscompares++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
        if (error !== 1'b0)        begin miscompares++; $display("[TB] FAIL reset_error: got %b, expected 0", error); end
        reset_n = 1'b1;
        @(negedge clk); trigger_computation = 1'b1;
        @(negedge clk); trigger_computation = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_trigger_unloaded: got busy %b, expected 0", busy); end
    endtask

    task automatic test_square();
        xq = '{32'd0, 32'd1, 32'd2, 32'd3};
        load_vector(32'd4, 32'd2, 32'd0, 32'd0);
        compute_and_read(4, 1'b1);
        check_run("square", 4);
        vectors++;
        if (first_lat !== 4 + 4) begin
            miscompares++;
            $display("[TB] FAIL square_latency: got %0d, expected %0d", first_lat, 8);
        end
    endtask

    task automatic test_mixed_coef();
        xq = '{32'd1, 32'd10, 32'h0000_FFFF};
        load_vector(32'd3, 32'd1, 32'd3, 32'd5);
        compute_and_read(3, 1'b0);
        check_run("mixed", 3);
        compute_and_read(3, 1'b0);
        check_run("mixed_retrigger", 3);
    endtask

    task automatic test_saturation();
        xq = '{32'h0000_FFFF, 32'd1, 32'd0, 32'h0001_0000};
        load_vector(32'd4, 32'hFFFF_FFFF, 32'd0, 32'd0);
        compute_and_read(4, 1'b1);
        check_run("saturation", 4);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int          n;
            logic [31:0] a, b, c;
            n = $urandom_range(1, 24);
            a = (r % 2 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            b = (r % 2 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            c = $urandom;
            xq.delete();
            for (int i = 0; i < n; i++) begin
                xq.push_back((r % 2 == 0) ? 32'($urandom_range(0, 65535)) : $urandom);
            end
            load_vector(32'(n), a, b, c);
            @(negedge clk); wr_enable = 1'b1; rd_enable = 1'b1; in_data = $urandom;
            @(negedge clk); wr_enable = 1'b0; rd_enable = 1'b0;
            vectors++;
            if (valid_output !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL random_idle_ignore: got valid %b busy %b, expected 0 0", valid_output, busy);
            end
            compute_and_read(n, 1'b0);
            check_run("random", n);
        end
    endtask

    task automatic test_illegal_size();
        @(negedge clk); enable = 1'b1;
        @(negedge clk); enable = 1'b0; wr_enable = 1'b1; in_data = 32'd0;
        @(negedge clk); wr_enable = 1'b0;
        vectors++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL size_zero: got error %b busy %b, expected 1 0", error, busy);
        end
        @(negedge clk); trigger_computation = 1'b1;
        @(negedge clk); trigger_computation = 1'b0;
        vectors++;
        if (busy !== 1'b0 || error !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL size_zero_trigger: got busy %b error %b, expected 0 1", busy, error);
        end
        @(negedge clk); enable = 1'b1;
        @(negedge clk); enable = 1'b0;
        vectors++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL enable_clears_error: got error %b busy %b, expected 0 1", error, busy);
        end
        wr_enable = 1'b1; in_data = 32'(DEPTH + 1);
        @(negedge clk); wr_enable = 1'b0;
        vectors++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL size_over_depth: got error %b busy %b, expected 1 0", error, busy);
        end
        @(negedge clk); trigger_computation = 1'b1;
        @(negedge clk); trigger_computation = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL size_over_trigger: got busy %b, expected 0", busy);
        end
        xq = '{32'd7, 32'd9};
        load_vector(32'd2, 32'd3, 32'd4, 32'd5);
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reload_error: got %b, expected 0", error);
        end
        compute_and_read(2, 1'b1);
        check_run("after_error", 2);
    endtask

    task automatic test_full_depth();
        xq.delete();
        for (int i = 0; i < DEPTH; i++) xq.push_back($urandom);
        load_vector(32'(DEPTH), $urandom, $urandom, $urandom);
        compute_and_read(DEPTH, 1'b1);
        check_run("full_depth", DEPTH);
        vectors++;
        if (first_lat !== DEPTH + 4 || last_lat - first_lat !== DEPTH - 1) begin
            miscompares++;
            $display("[TB] FAIL full_depth_timing: got first %0d last %0d, expected first %0d last %0d",
                     first_lat, last_lat, DEPTH + 4, 2 * DEPTH + 3);
        end
    endtask

    task automatic test_reset_mid_tx();
        int seen;
        xq.delete();
        for (int i = 0; i < 8; i++) xq.push_back($urandom);
        load_vector(32'd8, 32'd1, 32'd0, 32'd1);
        seen = 0;
        @(negedge clk); trigger_computation = 1'b1; rd_enable = 1'b1;
        @(negedge clk); trigger_computation = 1'b0;
        for (int k = 0; k < 64 && seen < 3; k++) begin
            @(negedge clk);
            if (valid_output) seen++;
        end
        vectors++;
        if (seen !== 3) begin
            miscompares++;
            $display("[TB] FAIL mid_tx_reads: got %0d, expected 3", seen);
        end
        reset_n = 1'b0; rd_enable = 1'b0;
        #1;
        vectors++;
        if (out_data !== 32'd0 || valid_output !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_tx_reset: got out %h valid %b busy %b done %b error %b, expected all 0",
                     out_data, valid_output, busy, done, error);
        end
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk); trigger_computation = 1'b1;
        @(negedge clk); trigger_computation = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_tx_retrigger: got busy %b, expected 0", busy);
        end
        load_vector(32'd8, 32'd1, 32'd0, 32'd1);
        compute_and_read(8, 1'b0);
        check_run("after_reset", 8);
    endtask

    initial begin
        test_reset();
        test_square();
        test_mixed_coef();
        test_saturation();
        test_random();
        test_illegal_size();
        test_full_depth();
        test_reset_mid_tx();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
